// File: rtl/iter_div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and iteration constants.
package iter_div_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } div_state_e;

  localparam int DIV_ITER_CNT = 32;
  localparam int DIV_CNT_W    = 6;

endpackage : iter_div_unit_pkg

// File: rtl/iter_div_unit.sv
// Multi-cycle restoring radix-2 divider for div.w/mod.w/div.wu/mod.wu.
//   state  | meaning
//   IDLE   | waiting for start
//   PREP   | take magnitudes and result signs; divide-by-zero shortcut
//   ITER   | one quotient bit per cycle, MSB first, 32 cycles
//   FIX    | apply result signs and publish results
//   DONE   | done pulse; a new start may be accepted here
module iter_div_unit
  import iter_div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient_out,
  output logic [DATA_W-1:0] remainder_out,
  output logic              divide_by_zero,
  output logic              done,
  output logic              busy
);

  div_state_e             state_q, state_d;
  logic                   sgn_q, sgn_d;
  logic [DATA_W-1:0]      dvd_q, dvd_d;
  logic [DATA_W-1:0]      dvs_q, dvs_d;
  logic [DATA_W:0]        rem_q, rem_d;
  logic [DATA_W-1:0]      quo_q, quo_d;
  logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   q_neg_q, q_neg_d;
  logic                   r_neg_q, r_neg_d;
  logic [DATA_W-1:0]      qout_q, qout_d;
  logic [DATA_W-1:0]      rout_q, rout_d;
  logic                   dbz_q, dbz_d;
  logic [DATA_W:0]        trial;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    qout_d  = qout_q;
    rout_d  = rout_q;
    dbz_d   = dbz_q;
    // Shift the next dividend bit into the partial remainder before the trial subtract.
    trial   = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !flush) begin
          sgn_d   = signed_op;
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        q_neg_d = sgn_q & (dvd_q[DATA_W-1] ^ dvs_q[DATA_W-1]);
        r_neg_d = sgn_q & dvd_q[DATA_W-1];
        if (dvs_q == '0) begin
          qout_d  = '1;
          rout_d  = dvd_q;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          quo_d   = mag(dvd_q, sgn_q);
          dvs_d   = mag(dvs_q, sgn_q);
          rem_d   = '0;
          cnt_d   = DIV_CNT_W'(DIV_ITER_CNT);
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (trial >= {1'b0, dvs_q}) begin
          rem_d = trial - {1'b0, dvs_q};
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = trial;
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DIV_CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        qout_d  = q_neg_q ? (~quo_q + 1'b1) : quo_q;
        rout_d  = r_neg_q ? (~rem_q[DATA_W-1:0] + 1'b1) : rem_q[DATA_W-1:0];
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      qout_q  <= '0;
      rout_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient_out   = qout_q;
  assign remainder_out  = rout_q;
  assign divide_by_zero = dbz_q;
  assign done           = (state_q == S_DONE);
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule : iter_div_unit

// File: tb/tb_iter_div_unit.sv
// Directed bench for iter_div_unit: vector table plus flush/reset/back-to-back sequences.
module tb_iter_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient_out;
  logic [31:0] remainder_out;
  logic        divide_by_zero;
  logic        done;
  logic        busy;

  int n_pass = 0;
  int n_tot  = 0;

  iter_div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .quotient_out(quotient_out),
    .remainder_out(remainder_out), .divide_by_zero(divide_by_zero),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    bit          dbz;
    int          cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 of the operation.
  task automatic launch(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    signed_op = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Advances until done is seen (bounded); reports the cycle and whether busy stayed high.
  task automatic run_to_done(input int from_cyc, output int cyc, output bit busy_ok);
    cyc = from_cyc;
    busy_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    bit bok;
    bit saw_done;
    logic [31:0] q_hold;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,         32'd2,          1'b0, 35};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 35};
    vecs[2] = '{1'b0, 32'hFFFF_FFF9,  32'd2,        32'h7FFF_FFFC,  32'd1,          1'b0, 35};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,          1'b0, 35};
    vecs[4] = '{1'b0, 32'h0000_1234,  32'd0,        32'hFFFF_FFFF,  32'h0000_1234,  1'b1, 2};
    vecs[5] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,          1'b0, 35};
    vecs[6] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF,  1'b0, 35};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  32'd0,          1'b0, 35};
    vecs[8] = '{1'b0, 32'd5,          32'd10,       32'd0,          32'd5,          1'b0, 35};
    vecs[9] = '{1'b1, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 2};

    repeat (3) @(negedge clk);
    chk("reset_q",    quotient_out, 32'd0);
    chk("reset_r",    remainder_out, 32'd0);
    chk("reset_dbz",  {31'd0, divide_by_zero}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
      run_to_done(1, cyc, bok);
      chk($sformatf("v%0d_done_cyc", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_busy_run", i), {31'd0, bok}, 32'd1);
      chk($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_q", i), quotient_out, vecs[i].q);
      chk($sformatf("v%0d_r", i), remainder_out, vecs[i].r);
      chk($sformatf("v%0d_dbz", i), {31'd0, divide_by_zero}, {31'd0, vecs[i].dbz});
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d_q_hold", i), quotient_out, vecs[i].q);
    end

    // Start accepted in DONE: done still shown, next op proceeds.
    @(negedge clk);
    launch(1'b0, 32'd100, 32'd7);
    run_to_done(1, cyc, bok);
    chk("b2b_first_done_cyc", cyc, 35);
    chk("b2b_first_done", {31'd0, done}, 32'd1);
    signed_op = 1'b0; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_c1_done", {31'd0, done}, 32'd0);
    chk("b2b_c1_busy", {31'd0, busy}, 32'd1);
    chk("b2b_first_q_hold", quotient_out, 32'd14);
    run_to_done(1, cyc, bok);
    chk("b2b_second_cyc", cyc, 35);
    chk("b2b_second_q", quotient_out, 32'd3);
    chk("b2b_second_r", remainder_out, 32'd0);

    // Flush in cycle 10 of 50/5, restart 9/3 one cycle later, ignored start in cycle 20.
    @(negedge clk);
    launch(1'b0, 32'd50, 32'd5);
    saw_done = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    q_hold = quotient_out;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_q_hold", quotient_out, 32'd3);
    chk("flush_r_hold", remainder_out, 32'd0);
    launch(1'b0, 32'd9, 32'd3);
    for (int c = 1; c < 20; c++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    signed_op = 1'b1; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to_done(21, cyc, bok);
    chk("flush_no_early_done", {31'd0, saw_done}, 32'd0);
    chk("flush_second_cyc", cyc, 35);
    chk("flush_second_busy", {31'd0, bok}, 32'd1);
    chk("flush_second_q", quotient_out, 32'd3);
    chk("flush_second_r", remainder_out, 32'd0);

    // Flush and start together: nothing starts.
    @(negedge clk);
    flush = 1'b1; start = 1'b1; signed_op = 1'b0; dividend = 32'd8; divisor = 32'd2;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("flush_start_idle", {31'd0, saw_done}, 32'd0);
    chk("flush_start_q_hold", quotient_out, 32'd3);

    // Reset in cycle 15 of a signed op.
    launch(1'b1, 32'hFFFF_FF9C, 32'd7);
    saw_done = 1'b0;
    for (int c = 1; c < 15; c++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_q", quotient_out, 32'd0);
    chk("rst_r", remainder_out, 32'd0);
    chk("rst_dbz", {31'd0, divide_by_zero}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("rst_no_done", {31'd0, saw_done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule : tb_iter_div_unit
